// File: rtl/pkt_slot_fifo_pkg.sv
// ============================================================================
// Module   : pkt_slot_fifo_pkg
// Brief    : Shared FSM state types, error bit positions and width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pkt_slot_fifo_pkg;

    typedef enum logic [0:0] {
        W_CLOSED = 1'b0,
        W_OPEN   = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_HOLD = 1'b1
    } rd_state_t;

    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_IDX = 2;

    // Width able to hold a packet length from 0 to max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_slot_ram.sv
// ============================================================================
// Module   : pkt_slot_ram
// Brief    : Simple dual-port RAM, one write port, one synchronous read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_slot_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clock_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/pkt_slot_fifo.sv
// ============================================================================
// Module   : pkt_slot_fifo
// Brief    : Multi-slot packet buffer, random-index write/read, FIFO packet
//            order. Define PKT_SLOT_FIFO_ERR_EN to enable sticky err_flags_o.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_slot_fifo
    import pkt_slot_fifo_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int MAX_LEN   = 64,
    parameter  int NUM_SLOTS = 4,
    localparam int LEN_W     = len_w(MAX_LEN),
    localparam int IDX_W     = $clog2(MAX_LEN),
    localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              wr_next_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_open_o,
    output logic [LEN_W-1:0]  wr_len_o,
    input  logic              rd_next_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [LEN_W-1:0]  rd_len_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]  pkt_count_o,
    output logic [2:0]        err_flags_o
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);

    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [SLOT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SLOT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [SLOT_W-1:0] hold_ptr_q, hold_ptr_d;
    logic [LEN_W-1:0]  wr_len_q, wr_len_d;
    logic [LEN_W-1:0]  rd_len_q, rd_len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_gate_q, rd_gate_d;
    logic [LEN_W-1:0]  len_tbl_q [NUM_SLOTS];

    logic              commit, pop, open_ok, wr_ok, held_after;
    logic [LEN_W-1:0]  wr_idx_ext, rd_idx_ext, wr_len_upd;
    logic [CNT_W:0]    cnt_sum, occ_after;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        wr_idx_ext = LEN_W'(wr_idx_i);
        rd_idx_ext = LEN_W'(rd_idx_i);
        wr_ok      = (wr_state_q == W_OPEN) && wr_en_i && (wr_idx_ext < LEN_W'(MAX_LEN));
        wr_len_upd = (wr_ok && ((wr_idx_ext + LEN_W'(1)) > wr_len_q))
                   ? (wr_idx_ext + LEN_W'(1)) : wr_len_q;
        commit     = wr_next_i && (wr_state_q == W_OPEN);
        // A commit this cycle is never visible to a same-cycle pop.
        pop        = rd_next_i && (cnt_q != '0);
        held_after = pop || (!rd_next_i && (rd_state_q == R_HOLD));
        cnt_sum    = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(commit) - (CNT_W+1)'(pop);
        occ_after  = cnt_sum + (CNT_W+1)'(held_after);
        open_ok    = occ_after < (CNT_W+1)'(NUM_SLOTS);

        cnt_d      = (cnt_sum > (CNT_W+1)'(NUM_SLOTS)) ? CNT_W'(NUM_SLOTS) : cnt_sum[CNT_W-1:0];

        wr_state_d = wr_state_q;
        wr_ptr_d   = wr_ptr_q + SLOT_W'(commit);
        wr_len_d   = wr_len_upd;
        if (wr_next_i) begin
            wr_len_d   = '0;
            wr_state_d = open_ok ? W_OPEN : W_CLOSED;
        end

        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q + SLOT_W'(pop);
        hold_ptr_d = hold_ptr_q;
        rd_len_d   = rd_len_q;
        if (rd_next_i) begin
            if (pop) begin
                rd_state_d = R_HOLD;
                hold_ptr_d = rd_ptr_q;
                rd_len_d   = len_tbl_q[rd_ptr_q];
            end else begin
                rd_state_d = R_IDLE;
                rd_len_d   = '0;
            end
        end

        rd_gate_d = (rd_state_q == R_HOLD) && (rd_idx_ext < rd_len_q);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_state_q <= W_CLOSED;
            rd_state_q <= R_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hold_ptr_q <= '0;
            wr_len_q   <= '0;
            rd_len_q   <= '0;
            cnt_q      <= '0;
            rd_gate_q  <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            hold_ptr_q <= hold_ptr_d;
            wr_len_q   <= wr_len_d;
            rd_len_q   <= rd_len_d;
            cnt_q      <= cnt_d;
            rd_gate_q  <= rd_gate_d;
        end
    end

    // The commit captures the length including any same-cycle write.
    always_ff @(posedge clock_i) begin
        if (commit) begin
            len_tbl_q[wr_ptr_q] <= wr_len_upd;
        end
    end

    pkt_slot_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (SLOT_W + IDX_W)
    ) u_ram (
        .clock_i (clock_i),
        .we_i    (wr_ok),
        .waddr_i ({wr_ptr_q, wr_idx_i}),
        .wdata_i (wr_data_i),
        .raddr_i ({hold_ptr_q, rd_idx_i}),
        .rdata_o (ram_rdata)
    );

    assign wr_open_o   = (wr_state_q == W_OPEN);
    assign wr_len_o    = wr_len_q;
    assign rd_valid_o  = (rd_state_q == R_HOLD);
    assign rd_len_o    = rd_len_q;
    assign rd_data_o   = rd_gate_q ? ram_rdata : '0;
    assign pkt_count_o = cnt_q;

`ifdef PKT_SLOT_FIFO_ERR_EN
    logic [2:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (wr_next_i && !open_ok) err_d[ERR_OVF] = 1'b1;
        if (rd_next_i && !pop)     err_d[ERR_UNF] = 1'b1;
        if (wr_en_i && !wr_ok)     err_d[ERR_IDX] = 1'b1;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 3'b000;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_flags_o = err_q;
`else
    assign err_flags_o = 3'b000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pkt_slot_fifo.sv
// ============================================================================
// Module   : tb_pkt_slot_fifo
// Brief    : Directed self-checking bench for pkt_slot_fifo (NUM_SLOTS=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pkt_slot_fifo;

    localparam int DATA_W    = 8;
    localparam int MAX_LEN   = 64;
    localparam int NUM_SLOTS = 4;
    localparam int LEN_W     = 7;
    localparam int IDX_W     = 6;
    localparam int CNT_W     = 3;

`ifdef PKT_SLOT_FIFO_ERR_EN
    localparam logic [2:0] ERR_MASK = 3'b111;
`else
    localparam logic [2:0] ERR_MASK = 3'b000;
`endif

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic              wr_next_i, wr_en_i, rd_next_i;
    logic [IDX_W-1:0]  wr_idx_i, rd_idx_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_open_o, rd_valid_o;
    logic [LEN_W-1:0]  wr_len_o, rd_len_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [CNT_W-1:0]  pkt_count_o;
    logic [2:0]        err_flags_o;

    int                checks   = 0;
    int                failures = 0;
    logic [2:0]        err_exp  = 3'b000;

    always #5 clock_i = ~clock_i;

    pkt_slot_fifo #(
        .DATA_W    (DATA_W),
        .MAX_LEN   (MAX_LEN),
        .NUM_SLOTS (NUM_SLOTS)
    ) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .wr_next_i   (wr_next_i),
        .wr_en_i     (wr_en_i),
        .wr_idx_i    (wr_idx_i),
        .wr_data_i   (wr_data_i),
        .wr_open_o   (wr_open_o),
        .wr_len_o    (wr_len_o),
        .rd_next_i   (rd_next_i),
        .rd_idx_i    (rd_idx_i),
        .rd_valid_o  (rd_valid_o),
        .rd_len_o    (rd_len_o),
        .rd_data_o   (rd_data_o),
        .pkt_count_o (pkt_count_o),
        .err_flags_o (err_flags_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_wr_next();
        wr_next_i = 1'b1;
        tick();
        wr_next_i = 1'b0;
    endtask

    task automatic do_rd_next();
        rd_next_i = 1'b1;
        tick();
        rd_next_i = 1'b0;
    endtask

    task automatic do_both_next();
        wr_next_i = 1'b1;
        rd_next_i = 1'b1;
        tick();
        wr_next_i = 1'b0;
        rd_next_i = 1'b0;
    endtask

    task automatic write_word(input int idx, input int data);
        wr_en_i   = 1'b1;
        wr_idx_i  = IDX_W'(idx);
        wr_data_i = DATA_W'(data);
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic read_check(input string tag, input int idx, input int exp);
        rd_idx_i = IDX_W'(idx);
        tick();
        check_val(tag, rd_data_o, exp);
    endtask

    task automatic check_err(input string tag);
        check_val(tag, err_flags_o, err_exp & ERR_MASK);
    endtask

    initial begin
        reset_i   = 1'b1;
        wr_next_i = 1'b0;
        wr_en_i   = 1'b0;
        rd_next_i = 1'b0;
        wr_idx_i  = '0;
        rd_idx_i  = '0;
        wr_data_i = '0;
        tick();
        tick();
        reset_i = 1'b0;
        check_val("rst_wr_open", wr_open_o, 0);
        check_val("rst_wr_len", wr_len_o, 0);
        check_val("rst_rd_valid", rd_valid_o, 0);
        check_val("rst_rd_len", rd_len_o, 0);
        check_val("rst_count", pkt_count_o, 0);
        check_val("rst_rd_data", rd_data_o, 0);
        check_err("rst_err");

        // Packet A: eight words
        do_wr_next();
        check_val("open_a", wr_open_o, 1);
        check_val("open_a_len", wr_len_o, 0);
        for (int i = 0; i < 8; i++) write_word(i, 100 + i);
        check_val("a_len", wr_len_o, 8);

        // Packet B: four words
        do_wr_next();
        check_val("commit_a_count", pkt_count_o, 1);
        check_val("open_b_len", wr_len_o, 0);
        check_val("open_b", wr_open_o, 1);
        for (int i = 0; i < 4; i++) write_word(i, 200 + i);
        check_val("b_len", wr_len_o, 4);
        do_wr_next();
        check_val("commit_b_count", pkt_count_o, 2);

        do_rd_next();
        check_val("pop_a_valid", rd_valid_o, 1);
        check_val("pop_a_len", rd_len_o, 8);
        check_val("pop_a_count", pkt_count_o, 1);
        for (int i = 0; i < 8; i++) read_check("rd_a", i, 100 + i);
        read_check("rd_a_past_len", 8, 0);

        do_rd_next();
        check_val("pop_b_len", rd_len_o, 4);
        check_val("pop_b_count", pkt_count_o, 0);
        for (int i = 0; i < 4; i++) read_check("rd_b", i, 200 + i);
        read_check("rd_b_past_len", 4, 0);

        // Sparse packet C: only idx5
        write_word(5, 55);
        check_val("c_len", wr_len_o, 6);
        do_wr_next();
        check_val("commit_c_count", pkt_count_o, 1);
        do_rd_next();
        check_val("pop_c_len", rd_len_o, 6);
        read_check("rd_c_idx5", 5, 55);

        // Underflow: nothing committed
        do_rd_next();
        err_exp[1] = 1'b1;
        check_val("unf_valid", rd_valid_o, 0);
        check_val("unf_len", rd_len_o, 0);
        check_err("unf_err");
        read_check("unf_rd0", 0, 0);
        read_check("unf_rd5", 5, 0);

        // Fill all slots: slot3 len0, slot0 len2, slot1 len3 (same-cycle write), slot2 len0
        do_wr_next();
        write_word(1, 77);
        check_val("d_len", wr_len_o, 2);
        do_wr_next();
        wr_en_i   = 1'b1;
        wr_idx_i  = IDX_W'(2);
        wr_data_i = DATA_W'(99);
        wr_next_i = 1'b1;
        tick();
        wr_en_i   = 1'b0;
        wr_next_i = 1'b0;
        check_val("fill3_open", wr_open_o, 1);
        check_val("fill3_count", pkt_count_o, 3);
        do_wr_next();
        err_exp[0] = 1'b1;
        check_val("full_open", wr_open_o, 0);
        check_val("full_count", pkt_count_o, 4);
        check_val("full_len", wr_len_o, 0);
        check_err("ovf_err");
        write_word(0, 1);
        err_exp[2] = 1'b1;
        check_val("closed_wr_len", wr_len_o, 0);
        check_err("idx_err");

        // Pop without a held slot to release: still full
        do_both_next();
        check_val("both1_open", wr_open_o, 0);
        check_val("both1_valid", rd_valid_o, 1);
        check_val("both1_len", rd_len_o, 0);
        check_val("both1_count", pkt_count_o, 3);
        // Released slot is reused by the opening write slot
        do_both_next();
        check_val("both2_open", wr_open_o, 1);
        check_val("both2_len", rd_len_o, 2);
        check_val("both2_count", pkt_count_o, 2);
        read_check("rd_d_idx1", 1, 77);
        do_rd_next();
        check_val("pop_e_len", rd_len_o, 3);
        read_check("rd_e_idx2", 2, 99);
        read_check("rd_e_past_len", 3, 0);

        // Reset mid-write with two packets committed
        write_word(2, 5);
        do_wr_next();
        write_word(2, 6);
        check_val("pre_rst_count", pkt_count_o, 2);
        check_val("pre_rst_len", wr_len_o, 3);
        #2;
        reset_i = 1'b1;
        #1;
        err_exp = 3'b000;
        check_val("arst_open", wr_open_o, 0);
        check_val("arst_count", pkt_count_o, 0);
        check_val("arst_valid", rd_valid_o, 0);
        check_val("arst_wr_len", wr_len_o, 0);
        check_err("arst_err");
        tick();
        reset_i = 1'b0;
        do_wr_next();
        check_val("post_rst_open", wr_open_o, 1);
        check_val("post_rst_len", wr_len_o, 0);
        write_word(0, 11);
        do_wr_next();
        do_rd_next();
        check_val("post_rst_rd_len", rd_len_o, 1);
        read_check("post_rst_rd0", 0, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
